// File: rtl/ct_spsram_256x59_arb.sv
// Round-robin two-requester front end for a single-port 256x59 SRAM macro.
// Optional post-reset zero sweep of the array is built when CT_SPSRAM_ARB_INIT_EN is defined.
module ct_spsram_256x59_arb #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 59,
  parameter int DEPTH      = 256
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req0_vld,
  input  logic                  req0_wr,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic [DATA_WIDTH-1:0] req0_wmask,
  output logic                  req0_rdy,
  input  logic                  req1_vld,
  input  logic                  req1_wr,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  input  logic [DATA_WIDTH-1:0] req1_wmask,
  output logic                  req1_rdy,
  output logic                  rsp0_vld,
  output logic                  rsp1_vld,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic [DATA_WIDTH-1:0] ram_d,
  output logic                  ram_cen,
  output logic                  ram_gwen,
  output logic [DATA_WIDTH-1:0] ram_wen,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  if (DEPTH != (1 << ADDR_WIDTH)) begin : g_depth_chk
    $error("DEPTH must equal 2**ADDR_WIDTH");
  end

  logic                  init_act;
  logic [ADDR_WIDTH-1:0] init_addr;

`ifdef CT_SPSRAM_ARB_INIT_EN
  typedef enum logic {ST_INIT, ST_IDLE} state_t;
  state_t                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;

  // Sweep one entry per cycle; wrapping back to 0 ends the sweep.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == {ADDR_WIDTH{1'b1}}) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign init_act  = ~RST & (state_q == ST_INIT);
  assign init_addr = cnt_q;
  assign busy      = RST | (state_q == ST_INIT);
`else
  assign init_act  = 1'b0;
  assign init_addr = '0;
  assign busy      = 1'b0;
`endif

  // last1_q=1 means requester 1 won the last contested or uncontested grant.
  logic last1_q;
  logic rsp0_q, rsp1_q;
  logic open_slot, gnt0, gnt1;

  assign open_slot = ~RST & ~init_act;
  assign gnt0      = open_slot & req0_vld & (~req1_vld | last1_q);
  assign gnt1      = open_slot & req1_vld & (~req0_vld | ~last1_q);
  assign req0_rdy  = gnt0;
  assign req1_rdy  = gnt1;

  always_comb begin
    ram_cen  = 1'b1;
    ram_gwen = 1'b1;
    ram_wen  = '1;
    ram_a    = '0;
    ram_d    = '0;
    if (init_act) begin
      ram_cen  = 1'b0;
      ram_gwen = 1'b0;
      ram_wen  = '0;
      ram_a    = init_addr;
    end else if (gnt0) begin
      ram_cen = 1'b0;
      ram_a   = req0_addr;
      if (req0_wr) begin
        ram_gwen = 1'b0;
        ram_d    = req0_wdata;
        ram_wen  = ~req0_wmask;
      end
    end else if (gnt1) begin
      ram_cen = 1'b0;
      ram_a   = req1_addr;
      if (req1_wr) begin
        ram_gwen = 1'b0;
        ram_d    = req1_wdata;
        ram_wen  = ~req1_wmask;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      last1_q <= 1'b1;
      rsp0_q  <= 1'b0;
      rsp1_q  <= 1'b0;
    end else begin
      if (gnt0 | gnt1) last1_q <= gnt1;
      rsp0_q <= gnt0 & ~req0_wr;
      rsp1_q <= gnt1 & ~req1_wr;
    end
  end

  // Gating with RST drops a response that was in flight when reset hit.
  assign rsp0_vld  = rsp0_q & ~RST;
  assign rsp1_vld  = rsp1_q & ~RST;
  assign rsp_rdata = ram_q;

endmodule

// File: tb/tb_ct_spsram_256x59_arb.sv
// Randomized self-checking bench for ct_spsram_256x59_arb with a behavioural SRAM and
// a round-robin/memory reference model.
module tb_ct_spsram_256x59_arb;
  localparam int AW = 8;
  localparam int DW = 59;

  logic          CLK = 1'b0;
  logic          RST;
  logic          req0_vld, req0_wr, req1_vld, req1_wr;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_wdata, req0_wmask, req1_wdata, req1_wmask;
  logic          req0_rdy, req1_rdy, rsp0_vld, rsp1_vld, busy;
  logic [DW-1:0] rsp_rdata, ram_d, ram_wen, ram_q;
  logic [AW-1:0] ram_a;
  logic          ram_cen, ram_gwen;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model: last-granted requester and array contents
  bit            m_last1;
  logic [DW-1:0] m_mem [256];
  logic [DW-1:0] sram  [256];

  always #5 CLK = ~CLK;

  ct_spsram_256x59_arb dut (
    .CLK(CLK), .RST(RST),
    .req0_vld(req0_vld), .req0_wr(req0_wr), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_wmask(req0_wmask), .req0_rdy(req0_rdy),
    .req1_vld(req1_vld), .req1_wr(req1_wr), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_wmask(req1_wmask), .req1_rdy(req1_rdy),
    .rsp0_vld(rsp0_vld), .rsp1_vld(rsp1_vld), .rsp_rdata(rsp_rdata), .busy(busy),
    .ram_a(ram_a), .ram_d(ram_d), .ram_cen(ram_cen), .ram_gwen(ram_gwen),
    .ram_wen(ram_wen), .ram_q(ram_q)
  );

  // behavioural single-port SRAM, registered Q
  always @(posedge CLK) begin
    if (!ram_cen) begin
      if (!ram_gwen) sram[ram_a] <= (sram[ram_a] & ram_wen) | (ram_d & ~ram_wen);
      ram_q <= sram[ram_a];
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs;
    req0_vld = 0; req0_wr = 0; req0_addr = '0; req0_wdata = '0; req0_wmask = '0;
    req1_vld = 0; req1_wr = 0; req1_addr = '0; req1_wdata = '0; req1_wmask = '0;
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [DW-1:0] m);
    return (old & ~m) | (d & m);
  endfunction

  task automatic test_reset;
    bit exp_busy;
`ifdef CT_SPSRAM_ARB_INIT_EN
    exp_busy = 1;
`else
    exp_busy = 0;
`endif
    RST = 1;
    idle_inputs();
    req0_vld = 1; req1_vld = 1; req0_wr = 1; req0_addr = 8'h11;
    req0_wdata = '1; req0_wmask = '1;
    repeat (3) tick();
    @(negedge CLK);
    n_chk++;
    if ({req0_rdy, req1_rdy, rsp0_vld, rsp1_vld} !== 4'b0)
      $display("FAIL reset_hs: rdy/rsp=%b expected 0000", {req0_rdy, req1_rdy, rsp0_vld, rsp1_vld});
    else n_pass++;
    n_chk++;
    if ({ram_cen, ram_gwen} !== 2'b11 || ram_wen !== {DW{1'b1}})
      $display("FAIL reset_ctl: cen=%b gwen=%b wen=%h expected 1 1 all-ones", ram_cen, ram_gwen, ram_wen);
    else n_pass++;
    n_chk++;
    if (ram_a !== '0 || ram_d !== '0 || busy !== exp_busy)
      $display("FAIL reset_dat: a=%h d=%h busy=%b expected 0 0 %b", ram_a, ram_d, busy, exp_busy);
    else n_pass++;
    tick();
    idle_inputs();
    m_last1 = 1;
  endtask

  task automatic test_init_release;
    int bad;
    bad = 0;
`ifdef CT_SPSRAM_ARB_INIT_EN
    req0_vld = 1; req0_addr = 8'h05;
    RST = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge CLK);
      if (busy !== 1 || ram_a !== AW'(i) || ram_gwen !== 0 || ram_cen !== 0 ||
          ram_wen !== '0 || req0_rdy !== 0) begin
        if (bad == 0)
          $display("FAIL init_sweep: cycle %0d busy=%b a=%h gwen=%b rdy=%b expected 1 %h 0 0",
                   i + 1, busy, ram_a, ram_gwen, req0_rdy, i[7:0]);
        bad++;
      end
      tick();
    end
    n_chk++;
    if (bad == 0) n_pass++;
    @(negedge CLK);
    n_chk++;
    if (busy !== 0 || req0_rdy !== 1)
      $display("FAIL init_first_grant: busy=%b rdy0=%b expected 0 1", busy, req0_rdy);
    else n_pass++;
    m_last1 = 0;
    tick();
    req0_vld = 0;
    @(negedge CLK);
    n_chk++;
    if (rsp0_vld !== 1 || rsp_rdata !== '0)
      $display("FAIL init_zero_read: vld=%b data=%h expected 1 0", rsp0_vld, rsp_rdata);
    else n_pass++;
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    tick();
`else
    req1_vld = 1; req1_wr = 0; req1_addr = 8'h07;
    RST = 0;
    @(negedge CLK);
    n_chk++;
    if (busy !== 0 || req1_rdy !== 1 || ram_cen !== 0 || ram_a !== 8'h07 || ram_gwen !== 1)
      $display("FAIL noinit_grant: busy=%b rdy1=%b cen=%b a=%h gwen=%b expected 0 1 0 07 1",
               busy, req1_rdy, ram_cen, ram_a, ram_gwen);
    else n_pass++;
    m_last1 = 1;
    tick();
    req1_vld = 0;
    @(negedge CLK);
    n_chk++;
    if (rsp1_vld !== 1 || rsp0_vld !== 0 || busy !== 0)
      $display("FAIL noinit_rsp: rsp1=%b rsp0=%b busy=%b expected 1 0 0", rsp1_vld, rsp0_vld, busy);
    else n_pass++;
    tick();
    bad = bad;
`endif
  endtask

  task automatic test_write_read;
    logic [DW-1:0] d;
    d = 59'h5A5A5A5A5A5A5A5;
    req0_vld = 1; req0_wr = 1; req0_addr = 8'h3C; req0_wdata = d; req0_wmask = '1;
    @(negedge CLK);
    n_chk++;
    if (req0_rdy !== 1 || ram_gwen !== 0 || ram_a !== 8'h3C || ram_d !== d || ram_wen !== '0)
      $display("FAIL wr_drive: rdy=%b gwen=%b a=%h d=%h wen=%h expected 1 0 3c %h 0",
               req0_rdy, ram_gwen, ram_a, ram_d, ram_wen, d);
    else n_pass++;
    m_mem[8'h3C] = merge(m_mem[8'h3C], d, '1);
    m_last1 = 0;
    tick();
    req0_wr = 0;
    @(negedge CLK);
    n_chk++;
    if (req0_rdy !== 1 || rsp0_vld !== 0 || ram_gwen !== 1)
      $display("FAIL rd_drive: rdy=%b rsp0(after write)=%b gwen=%b expected 1 0 1", req0_rdy, rsp0_vld, ram_gwen);
    else n_pass++;
    tick();
    req0_vld = 0;
    @(negedge CLK);
    n_chk++;
    if (rsp0_vld !== 1 || rsp1_vld !== 0 || rsp_rdata !== m_mem[8'h3C])
      $display("FAIL wr_rd_back: vld=%b data=%h expected 1 %h", rsp0_vld, rsp_rdata, m_mem[8'h3C]);
    else n_pass++;
    tick();
    @(negedge CLK);
    n_chk++;
    if (rsp0_vld !== 0)
      $display("FAIL rsp_one_cycle: rsp0=%b expected 0", rsp0_vld);
    else n_pass++;
    tick();
  endtask

  task automatic test_alternate;
    bit e0;
    int bad;
    bad = 0;
    req0_vld = 1; req0_wr = 0; req0_addr = 8'h01;
    req1_vld = 1; req1_wr = 0; req1_addr = 8'h02;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      e0 = m_last1;
      if (req0_rdy !== e0 || req1_rdy !== !e0 || (i > 0 && (rsp0_vld !== !e0 || rsp1_vld !== e0))) begin
        $display("FAIL alternate: cycle %0d rdy=%b%b rsp=%b%b expected rdy=%b%b", i,
                 req0_rdy, req1_rdy, rsp0_vld, rsp1_vld, e0, !e0);
        bad++;
      end
      m_last1 = !e0;
      tick();
    end
    n_chk++;
    if (bad == 0) n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_masked_write;
    logic [DW-1:0] m, e;
    m = 59'h00000000FFFFFFF;
    req1_vld = 1; req1_wr = 1; req1_addr = 8'h40; req1_wdata = '1; req1_wmask = '1;
    @(negedge CLK);
    m_mem[8'h40] = merge(m_mem[8'h40], '1, '1);
    m_last1 = 1;
    tick();
    req1_wdata = '0; req1_wmask = m;
    @(negedge CLK);
    n_chk++;
    if (req1_rdy !== 1 || ram_wen !== ~m || ram_gwen !== 0)
      $display("FAIL mask_wen: rdy1=%b wen=%h expected 1 %h", req1_rdy, ram_wen, ~m);
    else n_pass++;
    m_mem[8'h40] = merge(m_mem[8'h40], '0, m);
    tick();
    req1_wr = 0;
    tick();
    req1_vld = 0;
    e = {DW{1'b1}} & ~m;
    @(negedge CLK);
    n_chk++;
    if (rsp1_vld !== 1 || rsp_rdata !== e || m_mem[8'h40] !== e)
      $display("FAIL mask_read: vld=%b data=%h expected 1 %h", rsp1_vld, rsp_rdata, e);
    else n_pass++;
    tick();
  endtask

  task automatic test_random;
    bit            g0, g1, er0, er1, nr0, nr1;
    logic [DW-1:0] ed, nd;
    int            bad;
    bad = 0;
    // prefill so every address in the random window has known contents
    for (int i = 0; i < 16; i++) begin
      req0_vld = 1; req0_wr = 1; req0_addr = AW'(i); req0_wmask = '1;
      req0_wdata = {$urandom, $urandom};
      m_mem[i] = req0_wdata;
      m_last1 = 0;
      tick();
    end
    idle_inputs();
    tick();
    er0 = 0; er1 = 0; ed = '0;
    for (int c = 0; c < 400; c++) begin
      if (!req0_vld || req0_rdy) begin
        req0_vld = ($urandom_range(0, 3) != 0); req0_wr = $urandom_range(0, 1);
        req0_addr = AW'($urandom_range(0, 15));
        req0_wdata = {$urandom, $urandom}; req0_wmask = {$urandom, $urandom};
      end
      if (!req1_vld || req1_rdy) begin
        req1_vld = ($urandom_range(0, 3) != 0); req1_wr = $urandom_range(0, 1);
        req1_addr = AW'($urandom_range(0, 15));
        req1_wdata = {$urandom, $urandom}; req1_wmask = {$urandom, $urandom};
      end
      g0 = req0_vld && (!req1_vld || m_last1);
      g1 = req1_vld && (!req0_vld || !m_last1);
      @(negedge CLK);
      if (req0_rdy !== g0 || req1_rdy !== g1 || ram_cen !== !(g0 || g1) ||
          rsp0_vld !== er0 || rsp1_vld !== er1 || ((er0 || er1) && rsp_rdata !== ed)) begin
        if (bad < 5)
          $display("FAIL random: cycle %0d rdy=%b%b cen=%b rsp=%b%b data=%h expected rdy=%b%b rsp=%b%b data=%h",
                   c, req0_rdy, req1_rdy, ram_cen, rsp0_vld, rsp1_vld, rsp_rdata, g0, g1, er0, er1, ed);
        bad++;
      end
      nr0 = 0; nr1 = 0; nd = '0;
      if (g0) begin
        if (req0_wr) m_mem[req0_addr] = merge(m_mem[req0_addr], req0_wdata, req0_wmask);
        else begin nr0 = 1; nd = m_mem[req0_addr]; end
      end
      if (g1) begin
        if (req1_wr) m_mem[req1_addr] = merge(m_mem[req1_addr], req1_wdata, req1_wmask);
        else begin nr1 = 1; nd = m_mem[req1_addr]; end
      end
      if (g0 || g1) m_last1 = g1;
      er0 = nr0; er1 = nr1; ed = nd;
      tick();
    end
    idle_inputs();
    @(negedge CLK);
    if (rsp0_vld !== er0 || rsp1_vld !== er1 || ((er0 || er1) && rsp_rdata !== ed)) begin
      $display("FAIL random_tail: rsp=%b%b data=%h expected %b%b %h", rsp0_vld, rsp1_vld, rsp_rdata, er0, er1, ed);
      bad++;
    end
    n_chk++;
    if (bad == 0) n_pass++;
    tick();
  endtask

  task automatic test_reset_mid;
    // read granted to req0 leaves the pointer favouring req1
    req0_vld = 1; req0_wr = 0; req0_addr = 8'h03;
    @(negedge CLK);
    n_chk++;
    if (req0_rdy !== 1) $display("FAIL mid_read_grant: rdy0=%b expected 1", req0_rdy);
    else n_pass++;
    tick();
    RST = 1;
    req0_vld = 0;
    @(negedge CLK);
    n_chk++;
    if (rsp0_vld !== 0 || ram_cen !== 1)
      $display("FAIL mid_rsp_kill: rsp0=%b cen=%b expected 0 1", rsp0_vld, ram_cen);
    else n_pass++;
    tick();
    tick();
    RST = 0;
    req0_vld = 1; req0_wr = 0; req0_addr = 8'h03;
    req1_vld = 1; req1_wr = 0; req1_addr = 8'h04;
`ifdef CT_SPSRAM_ARB_INIT_EN
    @(negedge CLK);
    n_chk++;
    if (busy !== 1 || ram_a !== 8'h00 || ram_gwen !== 0 || req0_rdy !== 0)
      $display("FAIL mid_init_restart: busy=%b a=%h gwen=%b rdy0=%b expected 1 00 0 0",
               busy, ram_a, ram_gwen, req0_rdy);
    else n_pass++;
    repeat (256) tick();
`endif
    @(negedge CLK);
    n_chk++;
    if (req0_rdy !== 1 || req1_rdy !== 0)
      $display("FAIL mid_ptr_reset: rdy=%b%b expected 10", req0_rdy, req1_rdy);
    else n_pass++;
    tick();
    idle_inputs();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram[i] = '0;
      m_mem[i] = '0;
    end
    ram_q = '0;
    RST = 1;
    idle_inputs();
    test_reset();
    test_init_release();
    test_alternate();
    test_write_read();
    test_masked_write();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
